// File: rtl/fpu_pkg.sv
// Shared fpu result types: status bit positions and the {status, data} record.
// Used by the result buffer and any consumer that decodes fpu status words.
package fpu_pkg;

    localparam int FPU_WORD_W   = 32;
    localparam int FPU_STATUS_W = 4;

    localparam int ST_EXACT     = 0;
    localparam int ST_OVERFLOW  = 1;
    localparam int ST_UNDERFLOW = 2;
    localparam int ST_INEXACT   = 3;

    typedef struct packed {
        logic [FPU_STATUS_W-1:0] status;
        logic [FPU_WORD_W-1:0]   data;
    } fpu_result_t;

endpackage

// File: rtl/fpu_result_buffer_sat_counter.sv
// Saturating event counter used for fpu result statistics.
// The counter holds at all-ones; clear wins over a same-cycle increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/fpu_result_buffer.sv
// First-word-fall-through buffer for fpu results with a sticky drop flag.
// Define FPU_RESULT_BUFFER_STATUS_CNT_EN to build the per-status saturating counters.
module fpu_result_buffer
    import fpu_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                    clock100KHz,
    input  logic                    reset,
    input  logic                    res_valid_in,
    input  logic [FPU_WORD_W-1:0]   data_in,
    input  logic [FPU_STATUS_W-1:0] status_in,
    input  logic                    rd_en_in,
    input  logic                    clr_in,
    output logic [FPU_WORD_W-1:0]   data_out,
    output logic [FPU_STATUS_W-1:0] status_out,
    output logic                    valid_out,
    output logic                    full_out,
    output logic [$clog2(DEPTH):0]  count_out,
    output logic                    drop_out,
    output logic [CNT_W-1:0]        cnt_exact_out,
    output logic [CNT_W-1:0]        cnt_ovf_out,
    output logic [CNT_W-1:0]        cnt_unf_out,
    output logic [CNT_W-1:0]        cnt_inex_out
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             drop_q, drop_d;

    fpu_result_t mem_q [DEPTH];
    fpu_result_t head;

    logic empty, full, push, pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign pop   = rd_en_in && !empty;
    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    assign push  = res_valid_in && (!full || pop);

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        drop_d = drop_q;
        if (clr_in) begin
            drop_d = 1'b0;
        end else if (res_valid_in && !push) begin
            drop_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clock100KHz or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    // NOTE: storage is deliberately not reset; stale words are never visible
    // because the read path is gated by count, and this keeps it a plain RAM.
    always_ff @(posedge clock100KHz) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{status: status_in, data: data_in};
        end
    end

    assign head       = mem_q[rd_ptr_q];
    assign data_out   = empty ? '0 : head.data;
    assign status_out = empty ? '0 : head.status;
    assign valid_out  = !empty;
    assign full_out   = full;
    assign count_out  = count_q;
    assign drop_out   = drop_q;

`ifdef FPU_RESULT_BUFFER_STATUS_CNT_EN
    // Only accepted pushes are counted; several status bits may fire together.
    sat_counter #(.W(CNT_W)) u_cnt_exact (
        .clk_i  (clock100KHz),
        .rst_ni (reset),
        .inc_i  (push && status_in[ST_EXACT]),
        .clr_i  (clr_in),
        .cnt_o  (cnt_exact_out)
    );

    sat_counter #(.W(CNT_W)) u_cnt_ovf (
        .clk_i  (clock100KHz),
        .rst_ni (reset),
        .inc_i  (push && status_in[ST_OVERFLOW]),
        .clr_i  (clr_in),
        .cnt_o  (cnt_ovf_out)
    );

    sat_counter #(.W(CNT_W)) u_cnt_unf (
        .clk_i  (clock100KHz),
        .rst_ni (reset),
        .inc_i  (push && status_in[ST_UNDERFLOW]),
        .clr_i  (clr_in),
        .cnt_o  (cnt_unf_out)
    );

    sat_counter #(.W(CNT_W)) u_cnt_inex (
        .clk_i  (clock100KHz),
        .rst_ni (reset),
        .inc_i  (push && status_in[ST_INEXACT]),
        .clr_i  (clr_in),
        .cnt_o  (cnt_inex_out)
    );
`else
    assign cnt_exact_out = '0;
    assign cnt_ovf_out   = '0;
    assign cnt_unf_out   = '0;
    assign cnt_inex_out  = '0;
`endif

endmodule

// File: tb/tb_fpu_result_buffer.sv
// Directed plus randomized bench for fpu_result_buffer against a queue-based model.
module tb_fpu_result_buffer;
    import fpu_pkg::*;

    localparam int DEPTH   = 8;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef FPU_RESULT_BUFFER_STATUS_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        res_valid_in;
    logic [31:0] data_in;
    logic [3:0]  status_in;
    logic        rd_en_in;
    logic        clr_in;
    logic [31:0] data_out;
    logic [3:0]  status_out;
    logic        valid_out;
    logic        full_out;
    logic [3:0]  count_out;
    logic        drop_out;
    logic [CNT_W-1:0] cnt_exact_out, cnt_ovf_out, cnt_unf_out, cnt_inex_out;

    int checks   = 0;
    int failures = 0;

    fpu_result_t model_q[$];
    bit          model_drop;
    int          model_cnt[4];

    fpu_result_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock100KHz   (clk),
        .reset         (reset),
        .res_valid_in  (res_valid_in),
        .data_in       (data_in),
        .status_in     (status_in),
        .rd_en_in      (rd_en_in),
        .clr_in        (clr_in),
        .data_out      (data_out),
        .status_out    (status_out),
        .valid_out     (valid_out),
        .full_out      (full_out),
        .count_out     (count_out),
        .drop_out      (drop_out),
        .cnt_exact_out (cnt_exact_out),
        .cnt_ovf_out   (cnt_ovf_out),
        .cnt_unf_out   (cnt_unf_out),
        .cnt_inex_out  (cnt_inex_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_cnt(input int idx);
        return CNT_EN ? model_cnt[idx] : 0;
    endfunction

    task automatic compare_all(input string ph);
        fpu_result_t head_exp;
        head_exp = (model_q.size() > 0) ? model_q[0] : '0;
        check({ph, ".valid"},  64'(valid_out),  64'(model_q.size() != 0));
        check({ph, ".count"},  64'(count_out),  64'(model_q.size()));
        check({ph, ".full"},   64'(full_out),   64'(model_q.size() == DEPTH));
        check({ph, ".data"},   64'(data_out),   64'(head_exp.data));
        check({ph, ".status"}, 64'(status_out), 64'(head_exp.status));
        check({ph, ".drop"},   64'(drop_out),   64'(model_drop));
        check({ph, ".cnt_exact"}, 64'(cnt_exact_out), 64'(exp_cnt(ST_EXACT)));
        check({ph, ".cnt_ovf"},   64'(cnt_ovf_out),   64'(exp_cnt(ST_OVERFLOW)));
        check({ph, ".cnt_unf"},   64'(cnt_unf_out),   64'(exp_cnt(ST_UNDERFLOW)));
        check({ph, ".cnt_inex"},  64'(cnt_inex_out),  64'(exp_cnt(ST_INEXACT)));
    endtask

    // Reference behaviour for one rising edge, evaluated from the current inputs.
    task automatic model_edge();
        bit do_pop, do_push;
        do_pop  = rd_en_in && (model_q.size() > 0);
        do_push = res_valid_in && ((model_q.size() < DEPTH) || do_pop);
        if (do_pop)  void'(model_q.pop_front());
        if (do_push) model_q.push_back('{status: status_in, data: data_in});
        if (clr_in) begin
            model_drop = 1'b0;
            for (int b = 0; b < 4; b++) model_cnt[b] = 0;
        end else begin
            if (res_valid_in && !do_push) model_drop = 1'b1;
            if (do_push)
                for (int b = 0; b < 4; b++)
                    if (status_in[b] && model_cnt[b] < CNT_MAX) model_cnt[b]++;
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        model_drop = 1'b0;
        for (int b = 0; b < 4; b++) model_cnt[b] = 0;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input bit v, input logic [31:0] d, input logic [3:0] s,
                        input bit rd, input bit clr, input string ph);
        res_valid_in = v;
        data_in      = d;
        status_in    = s;
        rd_en_in     = rd;
        clr_in       = clr;
        @(posedge clk);
        model_edge();
        #1;
        compare_all(ph);
        @(negedge clk);
        res_valid_in = 1'b0;
        rd_en_in     = 1'b0;
        clr_in       = 1'b0;
    endtask

    function automatic logic [3:0] onehot();
        return 4'b0001 << $urandom_range(0, 3);
    endfunction

    task automatic drain(input string ph);
        while (model_q.size() > 0) step(1'b0, '0, '0, 1'b1, 1'b0, ph);
    endtask

    initial begin
        reset        = 1'b0;
        res_valid_in = 1'b0;
        data_in      = '0;
        status_in    = '0;
        rd_en_in     = 1'b0;
        clr_in       = 1'b0;
        model_reset();

        repeat (3) @(negedge clk);
        compare_all("in_reset");
        reset = 1'b1;
        step(1'b0, '0, '0, 1'b0, 1'b0, "idle");
        step(1'b0, '0, '0, 1'b1, 1'b0, "rd_empty");

        step(1'b1, 32'h3FC00000, 4'b0001, 1'b0, 1'b0, "push1");
        check("push1.data_const", 64'(data_out), 64'h3FC00000);
        step(1'b0, '0, '0, 1'b1, 1'b0, "pop1");

        for (int i = 1; i <= 8; i++) step(1'b1, 32'(i), onehot(), 1'b0, 1'b0, "fill");
        check("fill.full_const", 64'(full_out), 64'd1);
        step(1'b1, 32'd9, onehot(), 1'b0, 1'b0, "overflow");
        check("overflow.drop_const", 64'(drop_out), 64'd1);
        drain("drain");
        for (int i = 0; i < 5; i++) step(1'b1, 32'($urandom), onehot(), 1'b0, 1'b0, "refill");
        drain("redrain");
        step(1'b0, '0, '0, 1'b0, 1'b1, "clr_drop");

        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'($urandom), onehot(), 1'b0, 1'b0, "fill2");
        step(1'b1, 32'hDEADBEEF, 4'b0010, 1'b1, 1'b0, "full_pushpop");
        check("full_pushpop.count_const", 64'(count_out), 64'd8);
        check("full_pushpop.drop_const", 64'(drop_out), 64'd0);
        for (int i = 0; i < DEPTH - 1; i++) step(1'b0, '0, '0, 1'b1, 1'b0, "drain2");
        check("deadbeef_head", 64'(data_out), 64'hDEADBEEF);
        step(1'b0, '0, '0, 1'b1, 1'b0, "pop_deadbeef");

        step(1'b1, 32'h40490FDB, 4'b1000, 1'b1, 1'b0, "empty_pushpop");
        check("empty_pushpop.count_const", 64'(count_out), 64'd1);
        drain("drain3");

        step(1'b0, '0, '0, 1'b0, 1'b1, "clr_cnt");
        for (int i = 0; i < 300; i++) step(1'b1, 32'($urandom), 4'b1010, 1'b1, 1'b0, "sat");
        if (CNT_EN) begin
            check("sat.ovf_const",   64'(cnt_ovf_out),   64'd255);
            check("sat.inex_const",  64'(cnt_inex_out),  64'd255);
            check("sat.exact_const", 64'(cnt_exact_out), 64'd0);
            check("sat.unf_const",   64'(cnt_unf_out),   64'd0);
        end
        drain("drain4");

        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'($urandom), 4'b1111, 1'b0, 1'b0, "fill3");
        step(1'b1, 32'h1, 4'b0001, 1'b0, 1'b0, "drop_again");
        step(1'b1, 32'h2, 4'b0001, 1'b0, 1'b1, "clr_vs_drop");
        check("clr_vs_drop.drop_const",  64'(drop_out),  64'd0);
        check("clr_vs_drop.count_const", 64'(count_out), 64'd8);
        drain("drain5");

        for (int i = 0; i < 300; i++)
            step(1'($urandom), 32'($urandom), 4'($urandom), ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 40) == 0), "random");

        drain("drain6");
        for (int i = 0; i < 5; i++) step(1'b1, 32'($urandom), onehot(), 1'b0, 1'b0, "fill5");
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
        @(negedge clk);
        reset = 1'b1;
        step(1'b0, '0, '0, 1'b1, 1'b0, "after_rst");
        step(1'b1, 32'h12345678, 4'b0100, 1'b0, 1'b0, "post_rst_push");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fpu_result_buffer.md
Name: fpu_result_buffer

Overview:
- Stage directly downstream of the fpu. Captures each completed result (32-bit IEEE-754 single word plus 4-bit status) on a valid strobe.
- Stores results in a small first-word-fall-through (FWFT) FIFO so a slower consumer (display/UART/bench checker) can drain them with a read handshake.
- Optionally keeps saturating per-status event counters for result statistics.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 2.
- CNT_W, 8, width of each status counter.

Ports:
- clock100KHz  in  1  system clock, 100 kHz, rising edge.
- reset  in  1  asynchronous, active-low reset.
- res_valid_in  in  1  one-cycle strobe: data_in/status_in hold a new fpu result.
- data_in  in  32  fpu result word.
- status_in  in  4  fpu status, one-hot per fpu_pkg encoding.
- rd_en_in  in  1  consumer pops the head entry this cycle.
- clr_in  in  1  synchronous clear of drop flag and counters (FIFO contents untouched).
- data_out  out  32  head entry data; 0 when empty.
- status_out  out  4  head entry status; 0 when empty.
- valid_out  out  1  head entry present (= !empty).
- full_out  out  1  count == DEPTH.
- count_out  out  $clog2(DEPTH)+1  entries stored.
- drop_out  out  1  sticky: a push was lost because the FIFO was full.
- cnt_exact_out, cnt_ovf_out, cnt_unf_out, cnt_inex_out  out  CNT_W each  per-status counters.

Behaviour:
- Reset (reset=0, async): wr_ptr=0, rd_ptr=0, count=0, drop_out=0, all counters 0. Outputs: valid_out=0, full_out=0, data_out=0, status_out=0.
- Storage: memory of DEPTH x 36 bits ({status,data}). Memory is not reset.
- Push:
  - Accepted on a rising edge when res_valid_in=1 and (count<DEPTH or pop this cycle).
  - Writes mem[wr_ptr]; wr_ptr increments modulo DEPTH.
- Pop: occurs when rd_en_in=1 and count>0; rd_ptr increments modulo DEPTH. rd_en_in while empty is ignored.
- FWFT read path:
  - data_out/status_out are a combinational read of mem[rd_ptr], gated to 0 when count==0.
  - A result pushed into an empty FIFO appears on outputs the cycle after the push edge (latency 1).
- Simultaneous push and pop:
  - Full: both occur; count stays DEPTH; no drop.
  - Empty: push only; count becomes 1.
  - Otherwise: both occur; count unchanged.
- Drop: push rejected (full and no pop) -> entry discarded, drop_out set to 1. Held until clr_in or reset.
- Counters:
  - On each accepted push, every counter whose status bit is set increments by 1. Multiple bits set -> multiple counters increment.
  - Each counter saturates at 2^CNT_W-1.
  - Rejected pushes do not count.
- clr_in=1: counters and drop_out go to 0 next edge. clr_in has priority over same-cycle increment and drop set. FIFO push/pop proceed normally.
- Reset asserted mid-operation: all state returns to reset values immediately; pending entries are lost.

Optional Feature:
- Macro: FPU_RESULT_BUFFER_STATUS_CNT_EN.
- Defined: counters implemented as above.
- Undefined: counter logic omitted. The cnt_*_out ports remain and are tied to 0. clr_in then affects only drop_out.

Decomposition:
- fpu_pkg holds:
  - status bit index constants: ST_EXACT=0, ST_OVERFLOW=1, ST_UNDERFLOW=2, ST_INEXACT=3
  - typedef fpu_result_t packed struct {logic [3:0] status; logic [31:0] data;}
  - localparam FPU_WORD_W=32, FPU_STATUS_W=4
- One natural sub-module: sat_counter (parameter W; inputs inc, clr; saturating output). Instantiated four times under the macro.

Test Plan:
- Reset then idle -> valid_out=0, count_out=0, data_out=0, drop_out=0, all counters 0.
- Push data 32'h3FC00000, status 4'b0001, FIFO empty -> next cycle valid_out=1, data_out=32'h3FC00000, status_out=4'b0001, count_out=1, cnt_exact_out=1. Pop -> valid_out=0, data_out=0.
- Push 8 results 32'h00000001..32'h00000008 with no pops -> full_out=1. 9th push -> drop_out=1, count stays 8. Drain 8 pops -> outputs return 1..8 in order; pointers wrap correctly on refill.
- Full FIFO, simultaneous push 32'hDEADBEEF and pop -> count_out stays 8, drop_out=0; 32'hDEADBEEF is read as the 8th pop afterwards.
- Empty FIFO, simultaneous push and rd_en_in -> count_out=1, entry retained.
- Status-counter checks (macro on, CNT_W=8):
  - 300 pushes with status 4'b1010, popping to avoid full -> cnt_ovf_out=cnt_inex_out=255 (saturated), the other two counters 0.
  - clr_in pulse -> all counters 0 and drop_out=0; FIFO count unaffected.
- Async reset asserted with 5 entries stored -> count_out=0 and valid_out=0 immediately, before the next clock edge.
